mch_counter: RTL and testbench

MCH_COUNTER -- requirements
Module: mch_counter

---
 rtl/mch_counter.sv | 119 +++++++++++
 tb/tb_mch_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mch_counter.sv
// Multi-channel down counter: NUM_CH independent IDLE/RUN channels with optional auto-reload.
// Optional per-channel pause input enabled by defining MCH_COUNTER_PAUSE_EN.

module mch_counter_ch #(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] val_i,
    input  logic                 reload_i,
    input  logic                 abort_i,
    input  logic                 pause_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] shn_q, shn_d;
    logic                 shr_q, shr_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shn_q   <= '0;
            shr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shn_q   <= shn_d;
            shr_q   <= shr_d;
            done_q  <= done_d;
        end
    end

    // Priority: abort, then start, then normal counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shn_d   = shn_q;
        shr_d   = shr_q;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start_i) begin
            if (val_i != '0) begin
                state_d = RUN;
                cnt_d   = val_i;
                shn_d   = val_i;
                shr_d   = reload_i;
            end else begin
                // Zero-length count: immediate terminal pulse, never enters RUN.
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
        end else if (state_q == RUN && !pause_i) begin
            if (cnt_q != '0) begin
                cnt_d  = cnt_q - 1'b1;
                done_d = (cnt_q == CNT_WIDTH'(1));
            end else if (shr_q) begin
                cnt_d = shn_q;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
endmodule

module mch_counter #(
    parameter int CNT_WIDTH = 7,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           start_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0] cnt_val_i,
    input  logic [NUM_CH-1:0]           reload_i,
    input  logic [NUM_CH-1:0]           abort_i,
`ifdef MCH_COUNTER_PAUSE_EN
    input  logic [NUM_CH-1:0]           pause_i,
`endif
    output logic [NUM_CH*CNT_WIDTH-1:0] cnt_o,
    output logic [NUM_CH-1:0]           busy_o,
    output logic [NUM_CH-1:0]           done_o
);
    logic [NUM_CH-1:0] pause_w;
`ifdef MCH_COUNTER_PAUSE_EN
    assign pause_w = pause_i;
`else
    assign pause_w = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mch_counter_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (start_i[c]),
            .val_i    (cnt_val_i[c*CNT_WIDTH +: CNT_WIDTH]),
            .reload_i (reload_i[c]),
            .abort_i  (abort_i[c]),
            .pause_i  (pause_w[c]),
            .cnt_o    (cnt_o[c*CNT_WIDTH +: CNT_WIDTH]),
            .busy_o   (busy_o[c]),
            .done_o   (done_o[c])
        );
    end
endmodule

// File: tb/tb_mch_counter.sv
// Bench for mch_counter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a start-time/period arithmetic model.

module tb_mch_counter;
    localparam int W  = 7;
    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     start_i = '0;
    logic [NC*W-1:0]   cnt_val_i = '0;
    logic [NC-1:0]     reload_i = '0;
    logic [NC-1:0]     abort_i = '0;
    logic [NC*W-1:0]   cnt_o;
    logic [NC-1:0]     busy_o;
    logic [NC-1:0]     done_o;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    mch_counter #(.CNT_WIDTH(W), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .cnt_val_i (cnt_val_i),
        .reload_i  (reload_i),
        .abort_i   (abort_i),
`ifdef MCH_COUNTER_PAUSE_EN
        .pause_i   ('0),
`endif
        .cnt_o     (cnt_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    // Model: a channel is described by its last start edge, N and reload mode;
    // outputs follow from the number of edges elapsed since that start.
    int ecnt;
    int act[NC];
    int st[NC];
    int nn[NC];
    int rl[NC];
    int z0[NC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt <= 0;
            for (int c = 0; c < NC; c++) begin
                act[c] <= 0; st[c] <= 0; nn[c] <= 0; rl[c] <= 0; z0[c] <= 0;
            end
        end else begin
            ecnt <= ecnt + 1;
            for (int c = 0; c < NC; c++) begin
                z0[c] <= 0;
                if (abort_i[c]) begin
                    act[c] <= 0;
                end else if (start_i[c]) begin
                    if (int'(cnt_val_i[c*W +: W]) != 0) begin
                        act[c] <= 1;
                        st[c]  <= ecnt + 1;
                        nn[c]  <= int'(cnt_val_i[c*W +: W]);
                        rl[c]  <= int'(reload_i[c]);
                    end else begin
                        act[c] <= 0;
                        z0[c]  <= 1;
                    end
                end
            end
        end
    end

    function automatic void model_exp(input int c, output int ecv, output int ebs, output int edn);
        int p, q;
        ecv = 0; ebs = 0; edn = 0;
        if (z0[c] != 0) begin
            edn = 1;
        end else if (act[c] != 0) begin
            p = ecnt - st[c];
            if (rl[c] != 0) begin
                q = p % (nn[c] + 1);
                ecv = nn[c] - q; ebs = 1; edn = (q == nn[c]) ? 1 : 0;
            end else if (p <= nn[c]) begin
                ecv = nn[c] - p; ebs = 1; edn = (p == nn[c]) ? 1 : 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            for (int c = 0; c < NC; c++) begin
                int ecv, ebs, edn, acv;
                model_exp(c, ecv, ebs, edn);
                acv = int'(cnt_o[c*W +: W]);
                checks++;
                if (acv != ecv || int'(busy_o[c]) != ebs || int'(done_o[c]) != edn) begin
                    failures++;
                    $display("FAIL model ch%0d edge%0d: got cnt=%0d busy=%0d done=%0d expected cnt=%0d busy=%0d done=%0d",
                             c, ecnt, acv, busy_o[c], done_o[c], ecv, ebs, edn);
                end
            end
        end
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(cnt_o[c*W +: W]);
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic go(input logic [NC-1:0] s, input logic [NC-1:0] r,
                      input logic [NC-1:0] a, input logic [NC*W-1:0] v);
        start_i = s; reload_i = r; abort_i = a; cnt_val_i = v;
        @(posedge clk);
        @(negedge clk);
        start_i = '0; reload_i = '0; abort_i = '0; cnt_val_i = '0;
    endtask

    initial begin
        int dl[NC];
        logic [NC*W-1:0] v;
        dl = '{1, 2, 6, 128};

        repeat (2) @(negedge clk);
        chk("reset cnt", int'(cnt_o), 0);
        chk("reset busy", int'(busy_o), 0);
        chk("reset done", int'(done_o), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // ch0 single shot N=50
        v = '0; v[0*W +: W] = 7'd50;
        go(4'b0001, 4'b0000, 4'b0000, v);
        chk("ch0 first cnt", cnt_of(0), 50);
        chk("ch0 busy", int'(busy_o[0]), 1);
        repeat (50) @(negedge clk);
        chk("ch0 term cnt", cnt_of(0), 0);
        chk("ch0 term done", int'(done_o[0]), 1);
        @(negedge clk);
        chk("ch0 done one cycle", int'(done_o[0]), 0);
        chk("ch0 idle busy", int'(busy_o[0]), 0);

        // ch1 auto-reload N=3, then abort
        v = '0; v[1*W +: W] = 7'd3;
        go(4'b0010, 4'b0010, 4'b0000, v);
        for (int i = 0; i < 8; i++) begin
            chk("ch1 reload cnt", cnt_of(1), 3 - (i % 4));
            chk("ch1 reload done", int'(done_o[1]), (i % 4 == 3) ? 1 : 0);
            @(negedge clk);
        end
        go(4'b0000, 4'b0000, 4'b0010, '0);
        chk("ch1 abort cnt", cnt_of(1), 0);
        chk("ch1 abort busy", int'(busy_o[1]), 0);
        repeat (6) @(negedge clk);
        chk("ch1 no done after abort", int'(done_o[1]), 0);

        // all channels N=0,1,5,127 simultaneously
        v = {7'd127, 7'd5, 7'd1, 7'd0};
        go(4'b1111, 4'b0000, 4'b0000, v);
        for (int t = 1; t <= 130; t++) begin
            for (int c = 0; c < NC; c++)
                chk($sformatf("all-start ch%0d done t%0d", c, t), int'(done_o[c]), (t == dl[c]) ? 1 : 0);
            @(negedge clk);
        end

        // ch2 restart mid-count, then start+abort together
        v = '0; v[2*W +: W] = 7'd20;
        go(4'b0100, 4'b0000, 4'b0000, v);
        repeat (10) @(negedge clk);
        chk("ch2 pre-restart cnt", cnt_of(2), 10);
        v = '0; v[2*W +: W] = 7'd5;
        go(4'b0100, 4'b0000, 4'b0000, v);
        for (int t = 0; t <= 5; t++) begin
            chk("ch2 restart cnt", cnt_of(2), 5 - t);
            chk("ch2 restart done", int'(done_o[2]), (t == 5) ? 1 : 0);
            if (t < 5) @(negedge clk);
        end
        @(negedge clk);
        v = '0; v[2*W +: W] = 7'd9;
        go(4'b0100, 4'b0000, 4'b0100, v);
        chk("ch2 start+abort busy", int'(busy_o[2]), 0);
        chk("ch2 start+abort cnt", cnt_of(2), 0);

        // asynchronous reset mid-count
        v = '0; v[0*W +: W] = 7'd40;
        go(4'b0001, 4'b0000, 4'b0000, v);
        repeat (15) @(negedge clk);
        chk("ch0 pre-reset cnt", cnt_of(0), 25);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset cnt", int'(cnt_o), 0);
        chk("async reset busy", int'(busy_o), 0);
        chk("async reset done", int'(done_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-reset cnt", int'(cnt_o), 0);
        chk("post-reset busy", int'(busy_o), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                start_i[c]  = ($urandom_range(0, 7) == 0);
                reload_i[c] = $urandom_range(0, 1) != 0;
                abort_i[c]  = ($urandom_range(0, 29) == 0);
                cnt_val_i[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 127))
                                                                  : W'($urandom_range(0, 8));
            end
            @(negedge clk);
        end
        start_i = '0; abort_i = '0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
